// File: rtl/afe_tot_readout_if.sv
// Control/SPI signal bundle between the lab controller, the TOT readout block and the AFE CPLD.
// The slave view belongs to the readout block; the master view is the controller/CPLD side.
interface afe_tot_readout_if #(
    parameter int unsigned N = 8
) ();
    logic         start;
    logic [N-1:0] gpio_data;
    logic         busy;
    logic         cs_b;
    logic         sclk;
    logic         mosi;
    logic         miso;
    logic [N-1:0] raw;
    logic [N-1:0] tot;
    logic         tot_valid;
    logic         tot_err;

    modport slave (
        input  start, gpio_data, miso,
        output busy, cs_b, sclk, mosi, raw, tot, tot_valid, tot_err
    );

    modport master (
        output start, gpio_data, miso,
        input  busy, cs_b, sclk, mosi, raw, tot, tot_valid, tot_err
    );
endinterface

// File: rtl/afe_tot_readout.sv
// SPI master reading the CPLD LFSR TOT counter (writing a GPIO byte in the same transfer),
// then decoding the LFSR state to a binary count by stepping a local LFSR copy from its seed.
module afe_tot_readout #(
    parameter int unsigned N         = 8,
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [N-1:0] SEED     = {N{1'b1}},
    parameter logic [N-1:0] TAPS     = N'(29),
    parameter bit           LSB_FIRST = 1'b0
) (
    input  logic              reg_clk,
    input  logic              rst,
    afe_tot_readout_if.slave  bus
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int unsigned BIT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(N - 1);
    localparam logic [N-1:0]     CNT_LAST  = {{(N-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DECODE, S_DONE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [BIT_W-1:0] bit_cnt;
    logic [N-1:0]     tx;
    logic [N-1:0]     rx;
    logic [N-1:0]     lfsr;
    logic [N-1:0]     cnt;

    function automatic logic lead_bit(input logic [N-1:0] v);
        return LSB_FIRST ? v[0] : v[N-1];
    endfunction

    function automatic logic [N-1:0] tx_advance(input logic [N-1:0] v);
        return LSB_FIRST ? {1'b0, v[N-1:1]} : {v[N-2:0], 1'b0};
    endfunction

    function automatic logic [N-1:0] rx_advance(input logic [N-1:0] v, input logic b);
        return LSB_FIRST ? {b, v[N-1:1]} : {v[N-2:0], b};
    endfunction

    // Transfer sequencer, decoder and registered outputs
    always_ff @(posedge reg_clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            div           <= '0;
            bit_cnt       <= '0;
            tx            <= '0;
            rx            <= '0;
            lfsr          <= '0;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.cs_b      <= 1'b1;
            bus.sclk      <= 1'b0;
            bus.mosi      <= 1'b0;
            bus.raw       <= '0;
            bus.tot       <= '0;
            bus.tot_valid <= 1'b0;
            bus.tot_err   <= 1'b0;
        end else begin
            bus.tot_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        tx          <= bus.gpio_data;
                        bus.mosi    <= lead_bit(bus.gpio_data);
                        bus.tot_err <= 1'b0;
                        bus.cs_b    <= 1'b0;
                        bus.busy    <= 1'b1;
                        div         <= '0;
                        bit_cnt     <= '0;
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (div == HALF_LAST) begin
                        div   <= '0;
                        state <= S_SHIFT;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (div == HALF_LAST) begin
                        bus.sclk <= 1'b1;
                        rx       <= rx_advance(rx, bus.miso);
                        div      <= div + DIV_W'(1);
                    end else if (div == FULL_LAST) begin
                        // MOSI only moves on the falling SCLK so it is settled before each rise
                        bus.sclk <= 1'b0;
                        div      <= '0;
                        tx       <= tx_advance(tx);
                        if (bit_cnt == BIT_LAST) begin
                            bus.mosi <= 1'b0;
                            state    <= S_HOLD;
                        end else begin
                            bus.mosi <= lead_bit(tx_advance(tx));
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (div == HALF_LAST) begin
                        div      <= '0;
                        bus.cs_b <= 1'b1;
                        bus.raw  <= rx;
                        lfsr     <= SEED;
                        cnt      <= '0;
                        state    <= S_DECODE;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                S_DECODE: begin
                    if (lfsr == bus.raw) begin
                        bus.tot       <= cnt;
                        bus.tot_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Unreachable state (e.g. the all-zero lock-up word)
                        bus.tot       <= {N{1'b1}};
                        bus.tot_err   <= 1'b1;
                        bus.tot_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= S_DONE;
                    end else begin
                        lfsr <= {lfsr[N-2:0], ^(lfsr & TAPS)};
                        cnt  <= cnt + N'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_afe_tot_readout.sv
// Randomized bench for afe_tot_readout: a CPLD-side MISO driver plus a reference TOT decoder
// computed by walking the LFSR sequence from the seed.
module tb_afe_tot_readout;
    localparam int unsigned N       = 8;
    localparam int unsigned CLK_DIV = 4;
    localparam logic [7:0]  SEED    = 8'hFF;
    localparam logic [7:0]  TAPS    = 8'h1D;
    localparam int          CS_LOW_CYCLES = int'(CLK_DIV * (2 * N + 2));

    logic reg_clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    afe_tot_readout_if #(.N(N)) bus ();

    afe_tot_readout #(
        .N(N), .CLK_DIV(CLK_DIV), .SEED(SEED), .TAPS(TAPS), .LSB_FIRST(1'b0)
    ) dut (
        .reg_clk (reg_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 reg_clk = ~reg_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Position of a word in the LFSR sequence starting at SEED, or error if never reached
    function automatic void ref_decode(input logic [7:0] word, output logic [7:0] tot,
                                       output logic err, output int cycles);
        int v;
        v      = int'(SEED);
        tot    = 8'hFF;
        err    = 1'b1;
        cycles = 255;
        for (int k = 0; k < 255; k++) begin
            if (v == int'(word)) begin
                tot    = 8'(k);
                err    = 1'b0;
                cycles = k + 1;
                break;
            end
            v = ((v * 2) % 256) + ($countones(v & int'(TAPS)) % 2);
        end
    endfunction

    // One transfer: CPLD returns `word` MSB first; optional stray STARTs and a mid-SHIFT reset
    task automatic do_read(input logic [7:0] word, input logic [7:0] gpio,
                           input bit poke, input int abort_rise);
        logic [7:0] mosi_got;
        logic [7:0] exp_tot;
        logic       exp_err;
        int         dec, cyc, rises, last_rise, cs_low, extra;
        bit         prev_sclk, done, aborted;
        mosi_got = 8'h00;
        rises = 0; last_rise = 0; cs_low = 0; extra = 0;
        prev_sclk = 1'b0; done = 1'b0; aborted = 1'b0;
        ref_decode(word, exp_tot, exp_err, dec);

        @(negedge reg_clk);
        bus.start     = 1'b1;
        bus.gpio_data = gpio;
        @(negedge reg_clk);
        bus.start     = 1'b0;
        cyc = 1;
        check_eq("busy_after_start", 32'(bus.busy), 32'd1);
        while (!done && cyc < 1000) begin
            if (!bus.cs_b) cs_low++;
            if (bus.sclk && !prev_sclk) begin
                if (rises > 0) check_eq("sclk_period", 32'(cyc - last_rise), 32'(2 * CLK_DIV));
                last_rise = cyc;
                if (rises < int'(N)) mosi_got[int'(N) - 1 - rises] = bus.mosi;
                rises++;
                if (rises == abort_rise) begin
                    rst = 1'b1;
                    #1;
                    check_eq("abort_cs_b", 32'(bus.cs_b), 32'd1);
                    check_eq("abort_sclk", 32'(bus.sclk), 32'd0);
                    check_eq("abort_busy", 32'(bus.busy), 32'd0);
                    aborted = 1'b1;
                    done    = 1'b1;
                end
            end
            prev_sclk = bus.sclk;
            if (!aborted && bus.tot_valid) done = 1'b1;
            bus.miso      = (bus.cs_b || rises >= int'(N)) ? 1'($urandom) : word[int'(N) - 1 - rises];
            bus.gpio_data = 8'($urandom);
            bus.start     = poke && (cyc == 30 || (done && !aborted));
            if (!done) begin
                @(negedge reg_clk);
                cyc++;
            end
        end
        check_eq("tot_valid_seen", 32'(done), 32'd1);
        if (done && !aborted) begin
            check_eq("raw", 32'(bus.raw), 32'(word));
            check_eq("tot", 32'(bus.tot), 32'(exp_tot));
            check_eq("tot_err", 32'(bus.tot_err), 32'(exp_err));
            check_eq("latency", 32'(cyc), 32'(CS_LOW_CYCLES + dec + 1));
            check_eq("cs_b_low_cycles", 32'(cs_low), 32'(CS_LOW_CYCLES));
            check_eq("mosi_bits", 32'(mosi_got), 32'(gpio));
            check_eq("busy_at_valid", 32'(bus.busy), 32'd0);
            repeat (12) begin
                @(negedge reg_clk);
                bus.start = 1'b0;
                if (bus.tot_valid || bus.busy || !bus.cs_b) extra++;
            end
            check_eq("quiet_after_done", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] fixed_words [4];
        fixed_words = '{8'hFF, 8'hFE, 8'hFD, 8'hFA};
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.gpio_data = 8'h00;
        bus.miso      = 1'b0;
        repeat (3) @(negedge reg_clk);
        check_eq("rst_cs_b", 32'(bus.cs_b), 32'd1);
        check_eq("rst_sclk", 32'(bus.sclk), 32'd0);
        check_eq("rst_mosi", 32'(bus.mosi), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_raw", 32'(bus.raw), 32'd0);
        check_eq("rst_tot", 32'(bus.tot), 32'd0);
        check_eq("rst_valid", 32'(bus.tot_valid), 32'd0);
        check_eq("rst_err", 32'(bus.tot_err), 32'd0);
        rst = 1'b0;

        do_read(8'hFF, 8'hA5, 1'b0, -1);
        foreach (fixed_words[i]) do_read(fixed_words[i], 8'($urandom), 1'b0, -1);
        do_read(8'h00, 8'($urandom), 1'b1, -1);

        do_read(8'h3C, 8'($urandom), 1'b0, 4);
        repeat (2) @(negedge reg_clk);
        rst = 1'b0;
        repeat (20) @(negedge reg_clk);
        check_eq("post_abort_valid", 32'(bus.tot_valid), 32'd0);
        check_eq("post_abort_raw", 32'(bus.raw), 32'd0);
        check_eq("post_abort_tot", 32'(bus.tot), 32'd0);
        check_eq("post_abort_cs_b", 32'(bus.cs_b), 32'd1);
        do_read(8'hFA, 8'h5A, 1'b0, -1);

        for (int t = 0; t < 10; t++) begin
            do_read(8'($urandom), 8'($urandom), 1'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
